mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 50 +++++
 rtl/mem_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of every signal between the arbiter, its four
// requesters and the memory it drives.
//
// Signals:
//   req_valid[3:0]    requester -> arbiter  access request, held until accepted
//   req_wr_rd_s[3:0]  requester -> arbiter  op select per requester, 1=write 0=read
//   req_addr[31:0]    requester -> arbiter  packed 8-bit addresses, requester i at [8i+7:8i]
//   req_wr_data[31:0] requester -> arbiter  packed 8-bit write data, same packing
//   req_ready[3:0]    arbiter -> requester  one-hot combinational accept
//   rsp_valid[3:0]    arbiter -> requester  one-hot single-cycle completion pulse
//   rsp_rd_data[7:0]  arbiter -> requester  read data, 0 for writes
//   rsp_err           arbiter -> requester  timeout flag
//   mem_sel_en        arbiter -> memory     access strobe, held until acknowledged
//   mem_wr_rd_s       arbiter -> memory     1=write 0=read
//   mem_addr[7:0]     arbiter -> memory     access address
//   mem_wr_data[7:0]  arbiter -> memory     write data
//   mem_rd_data[7:0]  memory -> arbiter     read data, sampled with mem_ack
//   mem_ack           memory -> arbiter     access complete
//
// Modports:
//   master - the arbiter itself
//   slave  - the requesters and memory surrounding it
interface mem_arbiter_if;
    logic [3:0]  req_valid;
    logic [3:0]  req_wr_rd_s;
    logic [31:0] req_addr;
    logic [31:0] req_wr_data;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_rd_data;
    logic        rsp_err;
    logic        mem_sel_en;
    logic        mem_wr_rd_s;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wr_data;
    logic [7:0]  mem_rd_data;
    logic        mem_ack;

    modport master (
        input  req_valid, req_wr_rd_s, req_addr, req_wr_data, mem_rd_data, mem_ack,
        output req_ready, rsp_valid, rsp_rd_data, rsp_err,
               mem_sel_en, mem_wr_rd_s, mem_addr, mem_wr_data
    );

    modport slave (
        output req_valid, req_wr_rd_s, req_addr, req_wr_data, mem_rd_data, mem_ack,
        input  req_ready, rsp_valid, rsp_rd_data, rsp_err,
               mem_sel_en, mem_wr_rd_s, mem_addr, mem_wr_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that lets four requesters share a simple
// single-outstanding 8-bit memory bus. A two-state FSM (IDLE/ACCESS) accepts
// one request, holds the registered memory drive stable until the memory
// acknowledges, then returns a one-cycle response pulse to the requester
// that was granted.
//
// Ports:
//   clk    - single clock, all state on the rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - mem_arbiter_if.master: requester handshake, response and
//            memory bus (see rtl/mem_arbiter_if.sv)
//
// Parameters:
//   NUM_REQ        - number of requesters, only 4 is supported
//   TIMEOUT_CYCLES - ACCESS cycles before an unacknowledged access is aborted
//
// Optional feature:
//   MEM_ARB_TIMEOUT_EN - when defined, an access that sees no mem_ack for
//   TIMEOUT_CYCLES cycles is aborted and answered with rsp_err=1. When not
//   defined, ACCESS waits for mem_ack forever and rsp_err is tied low.
module mem_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] ptr;
    logic [1:0] grant;
    logic [1:0] winner;
    logic [1:0] cand;
    logic       any_req;
    logic       accept;
    logic       complete;
    logic       expire;
    logic       timeout_hit;
    logic [3:0] ready_vec;
    logic       sel_en_q;
    logic       wr_rd_s_q;
    logic [7:0] addr_q;
    logic [7:0] wr_data_q;
    logic [3:0] rsp_valid_q;
    logic [7:0] rsp_rd_data_q;

    if (NUM_REQ != 4) begin : g_bad_num_req
        $error("mem_arbiter supports NUM_REQ = 4 only");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mem_arbiter needs TIMEOUT_CYCLES >= 1");
    end

    // Round-robin search starting at ptr. The loop runs from the farthest
    // candidate back to ptr itself so the nearest requesting index is the
    // last one written and therefore wins.
    always_comb begin
        winner  = ptr;
        any_req = 1'b0;
        cand    = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (bus.req_valid[cand]) begin
                winner  = cand;
                any_req = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode. req_ready is gated with rst_n because
    // the state register already reads IDLE while reset is held, and nothing
    // may look accepted until reset has been released.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        complete   = 1'b0;
        expire     = 1'b0;
        ready_vec  = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    ready_vec[winner] = rst_n;
                    accept            = 1'b1;
                    state_next        = ACCESS;
                end
            end
            ACCESS: begin
                if (bus.mem_ack) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end else if (timeout_hit) begin
                    expire     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: latch the winner onto the memory bus at accept, hold it
    // through ACCESS, and turn the acknowledge (or abort) into a one-cycle
    // response pulse. Dropping mem_sel_en on completion and re-raising it
    // only on the next accept gives exactly one low cycle between accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr           <= 2'd0;
            grant         <= 2'd0;
            sel_en_q      <= 1'b0;
            wr_rd_s_q     <= 1'b0;
            addr_q        <= 8'h00;
            wr_data_q     <= 8'h00;
            rsp_valid_q   <= 4'b0000;
            rsp_rd_data_q <= 8'h00;
        end else begin
            rsp_valid_q <= 4'b0000;
            if (accept) begin
                ptr       <= winner + 2'd1;
                grant     <= winner;
                sel_en_q  <= 1'b1;
                wr_rd_s_q <= bus.req_wr_rd_s[winner];
                addr_q    <= bus.req_addr[{winner, 3'b000} +: 8];
                wr_data_q <= bus.req_wr_data[{winner, 3'b000} +: 8];
            end else if (complete || expire) begin
                sel_en_q      <= 1'b0;
                rsp_valid_q   <= 4'b0001 << grant;
                rsp_rd_data_q <= (complete && !wr_rd_s_q) ? bus.mem_rd_data : 8'h00;
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             rsp_err_q;

    // Counts completed ACCESS cycles; the last allowed cycle is
    // TIMEOUT_CYCLES-1, and an ack arriving on that same cycle still wins
    // because the FSM checks mem_ack before timeout_hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (accept) begin
            tmo_cnt <= '0;
        end else if (state == ACCESS) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    assign timeout_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // The error flag rides alongside the abort response pulse only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= expire;
        end
    end

    assign bus.rsp_err = rsp_err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.req_ready   = ready_vec;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rd_data = rsp_rd_data_q;
    assign bus.mem_sel_en  = sel_en_q;
    assign bus.mem_wr_rd_s = wr_rd_s_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wr_data = wr_data_q;

endmodule
